ssd_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for the board's 4-digit, common-anode 7-segment display.
- Holds a 16-bit BCD value (4 nibbles). Cycles one digit enable at a time at a divided refresh rate. Drives that digit's segment pattern.
- Sits between counter/FSM datapaths, which supply the value, and the FPGA pins ssd_ctl/ssd_seg.
- Contains its own BCD-to-segment lookup, so no external decoder instance is needed.

---
 rtl/ssd_scan_ctrl.sv | 141 ++++++++++++++
 tb/tb_ssd_scan_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_ctrl.sv
// Four-digit common-anode 7-segment scan controller with tear-free shadowing.
// Optional per-digit blinking is compiled in when SSD_SCAN_BLINK_EN is defined.
`timescale 1ns/1ps

module ssd_scan_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
`ifdef SSD_SCAN_BLINK_EN
  ,
  parameter int BLINK_DIV   = 50
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  input  logic        lz_en,
`ifdef SSD_SCAN_BLINK_EN
  input  logic [3:0]  blink,
`endif
  output logic        frame,
  output logic [3:0]  ssd_ctl,
  output logic [7:0]  ssd_seg
);

  logic [CNT_W-1:0] r_presc;
  logic [1:0]       r_idx;
  logic [15:0]      r_pend;
  logic [15:0]      r_shad;
  logic [3:0]       r_dp_pend;
  logic [3:0]       r_dp_shad;
  logic             r_frame;
  logic [3:0]       r_ctl;
  logic [7:0]       r_seg;

  logic             w_tick;
  logic             w_wrap;
  logic [3:0]       w_nib;
  logic [3:0]       w_blank;
  logic [7:0]       w_seg_next;

  function automatic logic [6:0] f_seg7(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      default: seg = 7'b0111000;
    endcase
    return seg;
  endfunction

  assign w_tick = (r_presc == CNT_W'(REFRESH_DIV - 1));
  assign w_wrap = w_tick && (r_idx == 2'd3);
  assign w_nib  = r_shad[{r_idx, 2'b00} +: 4];

  // A digit blanks only when it and every digit to its left are zero.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_blank
      if (gi == 0) begin : g_units
        assign w_blank[gi] = 1'b0;
      end else begin : g_upper
        assign w_blank[gi] = lz_en & ~(|r_shad[15:gi*4]);
      end
    end
  endgenerate

`ifdef SSD_SCAN_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [BW-1:0] r_blink_cnt;
  logic          r_blink_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (w_wrap) begin
      if (r_blink_cnt == BW'(BLINK_DIV - 1)) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + BW'(1);
      end
    end
  end
`endif

  always_comb begin
    w_seg_next = {w_blank[r_idx] ? 7'h7F : f_seg7(w_nib), ~r_dp_shad[r_idx]};
`ifdef SSD_SCAN_BLINK_EN
    if (r_blink_phase && blink[r_idx]) begin
      w_seg_next = 8'hFF;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc   <= '0;
      r_idx     <= 2'd0;
      r_pend    <= 16'h0000;
      r_shad    <= 16'h0000;
      r_dp_pend <= 4'b0000;
      r_dp_shad <= 4'b0000;
      r_frame   <= 1'b0;
      r_ctl     <= 4'b1111;
      r_seg     <= 8'hFF;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + CNT_W'(1);
      if (w_tick) begin
        r_idx <= r_idx + 2'd1;
      end
      if (load) begin
        r_pend    <= value;
        r_dp_pend <= dp;
      end
      // Shadow samples the pre-edge pending, so a load on the wrap tick waits a frame.
      if (w_wrap) begin
        r_shad    <= r_pend;
        r_dp_shad <= r_dp_pend;
      end
      r_frame <= w_wrap;
      r_ctl   <= ~(4'b0001 << r_idx);
      r_seg   <= w_seg_next;
    end
  end

  assign frame   = r_frame;
  assign ssd_ctl = r_ctl;
  assign ssd_seg = r_seg;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl with a 4-cycle digit slot (16-cycle frame).
`timescale 1ns/1ps

module tb_ssd_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0000;
  logic [3:0]  dp = 4'b0000;
  logic        lz_en = 1'b0;
  logic        frame;
  logic [3:0]  ssd_ctl;
  logic [7:0]  ssd_seg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ssd_scan_ctrl #(.REFRESH_DIV(4), .CNT_W(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .value  (value),
    .dp     (dp),
    .lz_en  (lz_en),
    .frame  (frame),
    .ssd_ctl(ssd_ctl),
    .ssd_seg(ssd_seg)
  );

  typedef struct {
    logic [15:0]     value;
    logic [3:0]      dp;
    logic            lz;
    logic [3:0][7:0] seg;   // seg[3] = digit3 ... seg[0] = digit0
  } vec_t;

  vec_t vecs[9];

  localparam logic [7:0] Z = 8'b00000011;   // '0', dp off

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Returns at the negedge on which frame is high.
  task automatic wait_frame(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame && n < 40);
    chk({name, "_frame_seen"}, {31'd0, frame}, 32'd1);
  endtask

  // Called at a frame-pulse negedge; samples the following 16 cycles (one full scan).
  task automatic scan16(input string name, input logic [3:0][7:0] exp);
    logic [3:0][7:0] got;
    logic [3:0]      seen;
    got  = '1;
    seen = 4'b0000;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      load = 1'b0;
      case (ssd_ctl)
        4'b1110: begin got[0] = ssd_seg; seen[0] = 1'b1; end
        4'b1101: begin got[1] = ssd_seg; seen[1] = 1'b1; end
        4'b1011: begin got[2] = ssd_seg; seen[2] = 1'b1; end
        4'b0111: begin got[3] = ssd_seg; seen[3] = 1'b1; end
        default: seen = seen;
      endcase
    end
    chk({name, "_all_digits"}, {28'd0, seen}, 32'hF);
    for (int d = 3; d >= 0; d--) begin
      chk($sformatf("%s_digit%0d", name, d), {24'd0, got[d]}, {24'd0, exp[d]});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] one;
    int         n;
    one = 4'b0001;

    vecs[0] = '{value: 16'h0070, dp: 4'b0000, lz: 1'b1, seg: {8'hFF, 8'hFF, 8'b00011111, Z}};
    vecs[1] = '{value: 16'h0070, dp: 4'b0000, lz: 1'b0, seg: {Z, Z, 8'b00011111, Z}};
    vecs[2] = '{value: 16'hA000, dp: 4'b1000, lz: 1'b0, seg: {8'b01110000, Z, Z, Z}};
    vecs[3] = '{value: 16'hA000, dp: 4'b1000, lz: 1'b1, seg: {8'b01110000, Z, Z, Z}};
    vecs[4] = '{value: 16'h5678, dp: 4'b0101, lz: 1'b0,
                seg: {8'b01001001, 8'b01000000, 8'b00011111, 8'b00000000}};
    vecs[5] = '{value: 16'h0009, dp: 4'b0100, lz: 1'b1,
                seg: {8'hFF, 8'b11111110, 8'hFF, 8'b00001001}};
    vecs[6] = '{value: 16'h0000, dp: 4'b0000, lz: 1'b1, seg: {8'hFF, 8'hFF, 8'hFF, Z}};
    vecs[7] = '{value: 16'h0C05, dp: 4'b0000, lz: 1'b1,
                seg: {8'hFF, 8'b01110001, Z, 8'b01001001}};
    vecs[8] = '{value: 16'hBE0D, dp: 4'b0010, lz: 1'b0,
                seg: {8'b01110001, 8'b01110001, 8'b00000010, 8'b01110001}};

    // Reset held.
    #22;
    chk("reset_ctl", {28'd0, ssd_ctl}, 32'hF);
    chk("reset_seg", {24'd0, ssd_seg}, 32'hFF);
    chk("reset_frame", {31'd0, frame}, 32'd0);
    $display("txn reset ctl=%b seg=%h frame=%b", ssd_ctl, ssd_seg, frame);

    // Scan order and frame cadence after release.
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      chk($sformatf("scan_ctl_c%0d", k), {28'd0, ssd_ctl}, {28'd0, ~(one << (((k - 1) / 4) % 4))});
      chk($sformatf("scan_frame_c%0d", k), {31'd0, frame}, (k == 16 || k == 32) ? 32'd1 : 32'd0);
    end
    $display("txn scan sequence checked over 32 cycles");

    // Load mid-frame: nothing changes until the next frame boundary.
    load = 1'b1; value = 16'h1234; dp = 4'b0000; lz_en = 1'b0;
    scan16("pre_frame_1234", {Z, Z, Z, Z});
    scan16("post_frame_1234", {8'b10011111, 8'b00100101, 8'b00001101, 8'b10011001});
    $display("txn load value=1234 dp=0000 lz=0");

    // Table of display vectors.
    for (int i = 0; i < 9; i++) begin
      value = vecs[i].value; dp = vecs[i].dp; lz_en = vecs[i].lz; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      wait_frame($sformatf("vec%0d", i));
      scan16($sformatf("vec%0d", i), vecs[i].seg);
      $display("txn vec %0d value=%h dp=%b lz=%b", i, vecs[i].value, vecs[i].dp, vecs[i].lz);
    end

    // Two loads in one frame: last wins.
    lz_en = 1'b0; dp = 4'b0000;
    value = 16'h1111; load = 1'b1;
    @(negedge clk);
    value = 16'h2222;
    @(negedge clk);
    load = 1'b0;
    wait_frame("last_wins");
    scan16("last_wins", {4{8'b00100101}});
    $display("txn double load 1111 then 2222");

    // Load on the wrap tick: old pending shown for one frame, then the new one.
    value = 16'h3333; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (14) @(negedge clk);
    value = 16'h4444; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("collide_frame", {31'd0, frame}, 32'd1);
    scan16("collide_old", {4{8'b00001101}});
    scan16("collide_new", {4{8'b10011001}});
    $display("txn load on wrap tick 3333 -> 4444");

    // Asynchronous reset while digit 2 is on the pins.
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ssd_ctl != 4'b1011 && n < 20);
    chk("async_find_digit2", {28'd0, ssd_ctl}, 32'hB);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_ctl", {28'd0, ssd_ctl}, 32'hF);
    chk("async_seg", {24'd0, ssd_seg}, 32'hFF);
    chk("async_frame", {31'd0, frame}, 32'd0);
    repeat (2) @(negedge clk);
    chk("async_hold_ctl", {28'd0, ssd_ctl}, 32'hF);
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart_ctl", {28'd0, ssd_ctl}, 32'hE);
    repeat (15) @(negedge clk);
    chk("restart_frame", {31'd0, frame}, 32'd1);
    scan16("after_reset", {Z, Z, Z, Z});
    $display("txn async reset mid-frame");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
